vx_branch_resolver: RTL
=======================

# vx_branch_resolver

Receiving end of the ALU blocks' branch-control outputs, located in the warp scheduler. It captures the branch resolutions produced by each ALU block into per-block queues and serialises them onto a single ready/valid update port that rewrites warp PCs. It also keeps the per-warp "stalled on branch" mask that gates issue. The branch-control producers have no backpressure, so this block must absorb every pulse or flag the loss.

## Interface
- NUM_BLOCKS, default `NUM_ALU_BLOCKS` (2): number of branch-control sources.
- NUM_WARPS, default `NUM_WARPS` (4): warps tracked.
- XLEN, default `XLEN` (32): PC width.
- NW_BITS, default `UP(CLOG2(NUM_WARPS))`: warp-id width.
- FIFO_DEPTH, default 2: entries per block queue; must be a power of 2 and ≥2.
- clk  in  1  clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- br_valid  in  NUM_BLOCKS  one-cycle resolution pulse per block; no ready.
- br_wid  in  NUM_BLOCKS*NW_BITS  warp id per block.
- br_taken  in  NUM_BLOCKS  branch taken.
- br_dest  in  NUM_BLOCKS*XLEN  resolved next PC.
- stall_set_valid  in  1  issue stage has dispatched a branch for stall_set_wid.
- stall_set_wid  in  NW_BITS  warp to mark stalled.
- upd_valid  out  1  resolution available.
- upd_ready  in  1  scheduler accepts the update.
- upd_wid / upd_taken / upd_pc  out  NW_BITS / 1 / XLEN  head entry of the granted queue.
- warp_stalled  out  NUM_WARPS  per-warp branch-stall mask.
- overflow  out  1  sticky: at least one resolution was dropped.
- resolved_count  out  32  updates transferred.

## Operation
- Each block owns one FIFO of FIFO_DEPTH entries. Entry = {wid, taken, dest}.
- br_valid[b] pushes into FIFO b in that cycle.
- Push into a full FIFO:
  - if the same FIFO pops in that cycle, the push is accepted;
  - otherwise the entry is dropped, overflow is set to 1, and the FIFO is unchanged.
- Arbitration is round-robin over non-empty FIFOs, starting at rr_ptr.
  - upd_* present the head of the granted FIFO.
  - upd_valid = any FIFO non-empty.
  - The grant and upd_* are combinational from registered state.
  - While upd_valid=1 and upd_ready=0, the grant and upd_* must hold stable.
- Transfer = upd_valid && upd_ready. On a transfer:
  - pop the granted FIFO;
  - rr_ptr ← (grant+1) mod NUM_BLOCKS;
  - warp_stalled[upd_wid] ← 0;
  - resolved_count increments, wrapping 2^32−1 → 0.
- stall_set_valid sets warp_stalled[stall_set_wid] ← 1.
  - If it targets the same warp as a transfer in the same cycle, set wins.
  - Different warps update independently in the same cycle.
- Multiple blocks pulsing in one cycle: all are captured, each in its own FIFO.
- Two entries for the same warp are delivered in FIFO/arbitration order. No merging.
- overflow clears only on reset.

## Timing
- Reset values: upd_valid=0, upd_wid=0, upd_taken=0, upd_pc=0, warp_stalled=0, overflow=0, resolved_count=0, rr_ptr=0, all FIFOs empty.
- Latency: br_valid at cycle N gives upd_valid at N+1 if no other entries are pending. Pass-through in the same cycle is not allowed.
- Transfer at cycle N: warp_stalled and resolved_count reflect it at N+1. The next head is presented at N+1.
- Sustained throughput is one update per cycle with upd_ready=1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Queued entries are discarded. Release is synchronous to clk.

## Test plan
- Single resolution:
  - Stimulus: stall_set wid=2 at cycle 0; br_valid[0], wid=2, dest=0x80000040, taken=1 at cycle 1; upd_ready=1.
  - Response: upd_valid=1 at cycle 2 with upd_pc=0x80000040; warp_stalled[2]=0 at cycle 3; resolved_count=1.
- Simultaneous sources:
  - Stimulus: br_valid=2'b11 (wid 0 and wid 1) in one cycle, rr_ptr=0.
  - Response: block 0 delivered first, then block 1 on the next cycle; rr_ptr ends at 0.
- Backpressure:
  - Stimulus: upd_ready=0 for 5 cycles with one entry queued.
  - Response: upd_* stable for all 5 cycles; on release, exactly one transfer.
- Overflow:
  - Stimulus: 3 pulses on block 0, upd_ready=0, FIFO_DEPTH=2.
  - Response: overflow=1 after the third pulse; the first two entries are delivered intact; resolved_count=2.
- Set/clear collision:
  - Stimulus: transfer for wid=1 and stall_set wid=1 in the same cycle.
  - Response: warp_stalled[1]=1 afterwards.
- Reset mid-operation:
  - Stimulus: assert reset with 2 entries queued.
  - Response: upd_valid=0 immediately; after release, counter=0 and no stale updates.

Source files
------------

// File: rtl/vx_branch_resolver.sv
// vx_branch_resolver: per-ALU-block branch resolution queues, round-robin
// serialised onto a single warp PC update port, plus the warp branch-stall mask.
module vx_branch_resolver #(
    parameter int NUM_BLOCKS = 2,
    parameter int NUM_WARPS  = 4,
    parameter int XLEN       = 32,
    parameter int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BLOCKS-1:0]        br_valid,
    input  logic [NUM_BLOCKS*NW_BITS-1:0] br_wid,
    input  logic [NUM_BLOCKS-1:0]        br_taken,
    input  logic [NUM_BLOCKS*XLEN-1:0]   br_dest,
    input  logic                         stall_set_valid,
    input  logic [NW_BITS-1:0]           stall_set_wid,
    output logic                         upd_valid,
    input  logic                         upd_ready,
    output logic [NW_BITS-1:0]           upd_wid,
    output logic                         upd_taken,
    output logic [XLEN-1:0]              upd_pc,
    output logic [NUM_WARPS-1:0]         warp_stalled,
    output logic                         overflow,
    output logic [31:0]                  resolved_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        logic               taken;
        logic [XLEN-1:0]    dest;
    } entry_t;

    entry_t              mem_q [NUM_BLOCKS][FIFO_DEPTH];
    entry_t              new_e [NUM_BLOCKS];
    logic [PW:0]         rd_q  [NUM_BLOCKS];
    logic [PW:0]         wr_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] empty;
    logic [NUM_BLOCKS-1:0] full;
    logic [NUM_BLOCKS-1:0] push;
    logic [NUM_BLOCKS-1:0] pop;
    logic [NUM_BLOCKS-1:0] drop;

    logic [BW-1:0]       rr_q;
    logic [BW-1:0]       rr_gnt;
    logic [BW-1:0]       gnt;
    logic [BW-1:0]       lock_gnt_q;
    logic                lock_q;
    logic                xfer;
    entry_t              head;
    logic [NUM_WARPS-1:0] ws_next;

    always_comb begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            empty[b] = (rd_q[b] == wr_q[b]);
            full[b]  = (rd_q[b][PW] != wr_q[b][PW]) &&
                       (rd_q[b][PW-1:0] == wr_q[b][PW-1:0]);
            new_e[b].wid   = br_wid[b*NW_BITS +: NW_BITS];
            new_e[b].taken = br_taken[b];
            new_e[b].dest  = br_dest[b*XLEN +: XLEN];
        end
    end

    // Round-robin search over non-empty queues starting at rr_q.
    always_comb begin
        int  idx;
        logic hit;
        rr_gnt = '0;
        hit    = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_BLOCKS) idx = idx - NUM_BLOCKS;
            if (!hit && !empty[idx]) begin
                hit    = 1'b1;
                rr_gnt = BW'(idx);
            end
        end
    end

    // A stalled grant is locked so late arrivals cannot steal the port.
    assign gnt       = lock_q ? lock_gnt_q : rr_gnt;
    assign upd_valid = ~&empty;
    assign head      = mem_q[gnt][rd_q[gnt][PW-1:0]];
    assign upd_wid   = upd_valid ? head.wid   : '0;
    assign upd_taken = upd_valid ? head.taken : 1'b0;
    assign upd_pc    = upd_valid ? head.dest  : '0;
    assign xfer      = upd_valid && upd_ready;

    always_comb begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            pop[b]  = xfer && (gnt == BW'(b));
            push[b] = br_valid[b] && (!full[b] || pop[b]);
            drop[b] = br_valid[b] && full[b] && !pop[b];
        end
    end

    // Set wins over the transfer clear when both hit the same warp.
    always_comb begin
        ws_next = warp_stalled;
        if (xfer) ws_next[upd_wid] = 1'b0;
        if (stall_set_valid) ws_next[stall_set_wid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (push[b]) mem_q[b][wr_q[b][PW-1:0]] <= new_e[b];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                rd_q[b] <= '0;
                wr_q[b] <= '0;
            end
            rr_q           <= '0;
            lock_q         <= 1'b0;
            lock_gnt_q     <= '0;
            warp_stalled   <= '0;
            overflow       <= 1'b0;
            resolved_count <= '0;
        end else begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (push[b]) wr_q[b] <= wr_q[b] + 1'b1;
                if (pop[b])  rd_q[b] <= rd_q[b] + 1'b1;
            end
            if (|drop) overflow <= 1'b1;
            lock_q     <= upd_valid && !upd_ready;
            lock_gnt_q <= gnt;
            if (xfer) begin
                rr_q <= (gnt == BW'(NUM_BLOCKS - 1)) ? '0 : gnt + 1'b1;
                resolved_count <= resolved_count + 32'd1;
            end
            warp_stalled <= ws_next;
        end
    end

endmodule
